endian_swap_pipe: RTL and testbench
===================================

# endian_swap_pipe

Registered, parametrised byte-order converter for the bus/memory interface path. Accepts beats of N_BYTES data plus byte enables over a valid/ready handshake and emits them one cycle later in one of four byte-order modes selected per beat. It sits between the core's load/store unit and the bus bridge, so the bridge sees a clean registered boundary with full-throughput backpressure.

## Interface
- N_BYTES, 4, bytes per beat; power of two, ≥ 4
- N_BITS, N_BYTES*8, data width (derived, not overridden)
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept the input beat
- in_data  in  N_BITS  input data, byte 0 = bits [7:0]
- in_be  in  N_BYTES  input byte enables, bit i qualifies byte i
- in_mode  in  2  byte-order mode for this beat; sampled with in_data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  N_BITS  swapped data
- out_be  out  N_BYTES  swapped byte enables, permuted identically to the data bytes

## Operation
- Modes (per beat, output byte j takes input byte p(j)):
  - 2'b00 PASS: p(j) = j
  - 2'b01 FULL: p(j) = N_BYTES-1-j
  - 2'b10 HALF: bytes swapped within each 16-bit halfword, p(j) = j XOR 1
  - 2'b11 WORD: bytes reversed within each 32-bit word, p(j) = j XOR 3
- The in_be permutation is identical to the data permutation; enables are never inverted or masked.
- Transfer occurs on a rising CLK edge when valid && ready on that side.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- in_mode is captured per beat; changing in_mode between beats requires no drain.
- While in_valid is high and in_ready is low, upstream holds in_data/in_be/in_mode stable. The block does not check this.

## Timing
- Reset values: out_valid=0, out_data=0, out_be=0. in_ready=1 in both configurations (see Configuration).
- Latency: an accepted beat is presented on out_* on the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready=1.
- out_valid is never deasserted and out_data/out_be never change while out_valid && !out_ready.
- Simultaneous accept-in and accept-out with the output register full: the register loads the new beat. out_valid stays 1.
- Reset asserted mid-stream: all held beats are discarded immediately (async). After nRST deasserts, the first accepted beat appears cleanly with no residue from the discarded beats.

## Configuration
- ENDIAN_SWAP_SKID_EN defined:
  - Two entries: output register plus skid register.
  - in_ready is a flop, equal to !skid_full. Reset value is 1.
  - A beat accepted while the output is stalled goes to the skid register.
  - When the output drains, the skid entry moves to the output before any newer beat.
  - in_ready reasserts the cycle after the skid entry empties.
  - No combinational path from out_ready to in_ready.
- ENDIAN_SWAP_SKID_EN undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Full throughput, but out_ready→in_ready is a combinational path.

## Structure
- Shared package endian_swap_pkg holds:
  - typedef enum logic [1:0] swap_mode_t {SWAP_PASS, SWAP_FULL, SWAP_HALF, SWAP_WORD}
  - localparam WORD_SIZE = 32
- Sub-module endian_swap_net:
  - Purely combinational, parametrised by N_BYTES.
  - Maps (data, be, mode) to (data', be'). Instantiated once, ahead of the registers.
- The top level holds only the handshake and storage logic.

## Test plan
- N_BYTES=4, out_ready=1:
  - 0x11223344, be 4'b0011, mode FULL → next cycle 0x44332211, be 4'b1100.
  - Same data, mode HALF → 0x22114433, be 4'b0011.
- N_BYTES=8, mode WORD, 0x1122334455667788, be 8'h0F → 0x4433221188776655, be 8'h0F. The same beat in mode FULL → 0x8877665544332211, be 8'hF0.
- Back-to-back beats D0..D3 with modes cycling PASS/FULL/HALF/WORD and out_ready=1: four consecutive out_valid cycles, each correctly swapped, in order.
- out_ready held low for 3 cycles with in_valid held high:
  - Skid build: in_ready drops after 2 accepted beats, out_data stable throughout.
  - Release: both beats emerge in order on consecutive cycles.
  - Non-skid build: in_ready drops after 1 accepted beat.
- nRST pulsed low while 2 beats are held: out_valid=0, out_data=0 and in_ready=1 immediately. The next beat after release is output alone and correct.
- Random valid/ready toggling over 10k beats checked against a reference queue: no loss, no duplication, no reordering.

Source files
------------

// File: rtl/endian_swap_pkg.sv
// Shared types and constants for the endian swap pipeline.
// Optional build macro (read by endian_swap_pipe): ENDIAN_SWAP_SKID_EN.
package endian_swap_pkg;

  // Width of the unit that WORD mode reverses bytes within.
  localparam int WORD_SIZE = 32;

  // Byte-order mode, sampled once per beat together with its data.
  typedef enum logic [1:0] {
    SWAP_PASS = 2'b00,
    SWAP_FULL = 2'b01,
    SWAP_HALF = 2'b10,
    SWAP_WORD = 2'b11
  } swap_mode_t;

endpackage

// File: rtl/endian_swap_net.sv
// Combinational byte permutation network. Output byte j takes input byte
// p(j), where p depends on the mode. The byte enables follow exactly the
// same permutation as the data bytes, so an enable always stays attached
// to its own byte.
module endian_swap_net
  import endian_swap_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic [N_BYTES*8-1:0] data_i,
  input  logic [N_BYTES-1:0]   be_i,
  input  swap_mode_t           mode_i,
  output logic [N_BYTES*8-1:0] data_o,
  output logic [N_BYTES-1:0]   be_o
);

  localparam int BYTES_PER_WORD = WORD_SIZE / 8;

  // One constant-index mux per output byte; the source indices are
  // elaboration-time constants so no variable part-selects are needed.
  for (genvar j = 0; j < N_BYTES; j++) begin : g_byte
    localparam int P_FULL = N_BYTES - 1 - j;
    localparam int P_HALF = j ^ 1;
    localparam int P_WORD = j ^ (BYTES_PER_WORD - 1);

    assign data_o[j*8 +: 8] = (mode_i == SWAP_FULL) ? data_i[P_FULL*8 +: 8] :
                              (mode_i == SWAP_HALF) ? data_i[P_HALF*8 +: 8] :
                              (mode_i == SWAP_WORD) ? data_i[P_WORD*8 +: 8] :
                                                      data_i[j*8 +: 8];

    assign be_o[j] = (mode_i == SWAP_FULL) ? be_i[P_FULL] :
                     (mode_i == SWAP_HALF) ? be_i[P_HALF] :
                     (mode_i == SWAP_WORD) ? be_i[P_WORD] :
                                             be_i[j];
  end

endmodule

// File: rtl/endian_swap_pipe.sv
// Registered byte-order converter between the load/store unit and the bus
// bridge. The swap is done combinationally ahead of the storage, so the
// output is a clean registered boundary.
// Build macro: ENDIAN_SWAP_SKID_EN adds a skid register so that in_ready
// is a flop with no combinational path from out_ready. Without it a single
// output register is used and in_ready = !out_valid || out_ready.
//
// Handshake: on either side a beat transfers on a rising CLK edge where
// valid && ready are both high; a producer holding valid high must keep its
// payload stable until that edge, and the output side never drops out_valid
// or changes out_data/out_be while out_valid && !out_ready.
module endian_swap_pipe
  import endian_swap_pkg::*;
#(
  parameter  int N_BYTES = 4,
  localparam int N_BITS  = N_BYTES * 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic [N_BYTES-1:0] in_be,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic [N_BYTES-1:0] out_be
);

  logic [N_BITS-1:0]  sw_data;
  logic [N_BYTES-1:0] sw_be;

  endian_swap_net #(
    .N_BYTES (N_BYTES)
  ) u_net (
    .data_i (in_data),
    .be_i   (in_be),
    .mode_i (swap_mode_t'(in_mode)),
    .data_o (sw_data),
    .be_o   (sw_be)
  );

  logic               out_valid_q, out_valid_d;
  logic [N_BITS-1:0]  out_data_q,  out_data_d;
  logic [N_BYTES-1:0] out_be_q,    out_be_d;
  logic               in_fire;
  logic               out_free;

  assign out_free  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_be    = out_be_q;

`ifdef ENDIAN_SWAP_SKID_EN
  logic               skid_full_q, skid_full_d;
  logic [N_BITS-1:0]  skid_data_q, skid_data_d;
  logic [N_BYTES-1:0] skid_be_q,   skid_be_d;

  // in_ready is the registered "skid empty" flag.
  assign in_ready = !skid_full_q;

  // Next state: the skid entry always drains into the output before any
  // newer beat; a beat arriving while the output is stalled parks in skid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    skid_be_d   = skid_be_q;
    if (out_free) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_be_d    = skid_be_q;
        skid_full_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = sw_data;
        out_be_d    = sw_be;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_full_d = 1'b1;
      skid_data_d = sw_data;
      skid_be_d   = sw_be;
    end
  end

  // Skid storage; reset discards any parked beat.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_be_q   <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      skid_be_q   <= skid_be_d;
    end
  end
`else
  // Accept whenever the output register is empty or draining this cycle.
  assign in_ready = out_free;

  // Next state: load on accept, otherwise clear valid once drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = sw_data;
      out_be_d    = sw_be;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output register; reset discards the held beat and zeroes the payload.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
    end
  end

endmodule

// File: tb/tb_endian_swap_pipe.sv
// Self-checking bench for endian_swap_pipe: a 4-byte instance with a
// scoreboard queue plus a 8-byte instance for the wide-bus vectors.
module tb_endian_swap_pipe;
  import endian_swap_pkg::*;

`ifdef ENDIAN_SWAP_SKID_EN
  localparam int EXP_ACC    = 2;
  localparam int EXP_SECOND = 1;
`else
  localparam int EXP_ACC    = 1;
  localparam int EXP_SECOND = 0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  // 4-byte instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_be, out_be;
  logic [1:0]  in_mode;

  // 8-byte instance
  logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
  logic [63:0] v8_in_data, v8_out_data;
  logic [7:0]  v8_in_be, v8_out_be;
  logic [1:0]  v8_in_mode;

  endian_swap_pipe #(.N_BYTES(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_be(in_be), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_be(out_be)
  );

  endian_swap_pipe #(.N_BYTES(8)) dut8 (
    .CLK(CLK), .nRST(nRST),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .in_data(v8_in_data), .in_be(v8_in_be), .in_mode(v8_in_mode),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready),
    .out_data(v8_out_data), .out_be(v8_out_be)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int pushed   = 0;
  int popped   = 0;
  logic [35:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference byte permutation: returns {data[63:0], be[7:0]}.
  function automatic logic [71:0] model(input logic [63:0] d, input logic [7:0] be,
                                        input logic [1:0] m, input int n);
    logic [63:0] rd;
    logic [7:0]  rb;
    int p;
    rd = '0;
    rb = '0;
    for (int j = 0; j < n; j++) begin
      case (m)
        2'd0:    p = j;
        2'd1:    p = n - 1 - j;
        2'd2:    p = j ^ 1;
        default: p = j ^ 3;
      endcase
      rd = rd | (((d >> (8 * p)) & 64'hFF) << (8 * j));
      rb = rb | (((be >> p) & 8'h01) << j);
    end
    return {rd, rb};
  endfunction

  // Monitor: compare the held output with the queue head every cycle it is
  // valid (also covers stability under stall), pop on transfer, push on accept.
  always @(negedge CLK) begin
    logic [71:0] r;
    if (nRST) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check_eq("out_data", 64'(out_data), 64'(exp_q[0][35:4]));
          check_eq("out_be", 64'(out_be), 64'(exp_q[0][3:0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready) begin
        r = model({32'd0, in_data}, {4'd0, in_be}, in_mode, 4);
        exp_q.push_back({r[39:8], r[3:0]});
        pushed++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input logic [3:0] be, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_be    = be;
    in_mode  = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      #1;
    end
    if (!ok) check_eq("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  // Hold out_ready low for 3 cycles while offering beats; returns accepts.
  task automatic stall_fill(output int acc);
    bit fired;
    acc       = 0;
    out_ready = 1'b0;
    in_data   = 32'hA1B2C3D4;
    in_be     = 4'b1001;
    in_mode   = SWAP_FULL;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      fired = in_ready;
      @(posedge CLK);
      #1;
      if (fired) begin
        acc++;
        in_data = 32'h0BADCAFE;
        in_be   = 4'b0110;
        in_mode = SWAP_WORD;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [63:0] d, input logic [7:0] be, input logic [1:0] m);
    v8_in_data  = d;
    v8_in_be    = be;
    v8_in_mode  = m;
    v8_in_valid = 1'b1;
    @(posedge CLK);
    #1;
    v8_in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [71:0] r;
    logic [31:0] d;
    int acc;
    int sent;
    bit fired;

    nRST = 1'b0;
    in_valid = 1'b0; in_data = '0; in_be = '0; in_mode = '0; out_ready = 1'b1;
    v8_in_valid = 1'b0; v8_in_data = '0; v8_in_be = '0; v8_in_mode = '0;
    v8_out_ready = 1'b1;

    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_be", 64'(out_be), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst8_out_valid", 64'(v8_out_valid), 64'd0);
    check_eq("rst8_out_data", v8_out_data, 64'd0);
    check_eq("rst8_in_ready", 64'(v8_in_ready), 64'd1);
    @(posedge CLK); #2;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Directed 4-byte vectors, one-cycle latency.
    send(32'h11223344, 4'b0011, SWAP_FULL);
    check_eq("full_valid", 64'(out_valid), 64'd1);
    check_eq("full_data", 64'(out_data), 64'h44332211);
    check_eq("full_be", 64'(out_be), 64'hC);
    send(32'h11223344, 4'b0011, SWAP_HALF);
    check_eq("half_data", 64'(out_data), 64'h22114433);
    check_eq("half_be", 64'(out_be), 64'h3);

    // Directed 8-byte vectors.
    send8(64'h1122334455667788, 8'h0F, SWAP_WORD);
    check_eq("w8_valid", 64'(v8_out_valid), 64'd1);
    check_eq("w8_data", v8_out_data, 64'h4433221188776655);
    check_eq("w8_be", 64'(v8_out_be), 64'h0F);
    send8(64'h1122334455667788, 8'h0F, SWAP_FULL);
    check_eq("f8_data", v8_out_data, 64'h8877665544332211);
    check_eq("f8_be", 64'(v8_out_be), 64'hF0);

    // Back-to-back beats cycling through all modes.
    for (int k = 0; k < 4; k++) begin
      d = 32'h01020304 + 32'h10101010 * k;
      send(d, 4'(4'b0001 << k), 2'(k));
      r = model({32'd0, d}, {4'd0, 4'(4'b0001 << k)}, 2'(k), 4);
      check_eq("b2b_valid", 64'(out_valid), 64'd1);
      check_eq("b2b_data", 64'(out_data), 64'(r[39:8]));
      check_eq("b2b_be", 64'(out_be), 64'(r[3:0]));
    end
    @(posedge CLK); #1;

    // Stall with in_valid held, then release.
    stall_fill(acc);
    check_eq("stall_accepted", 64'(acc), 64'(EXP_ACC));
    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge CLK);
    check_eq("release_first", 64'(out_valid), 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("release_second", 64'(out_valid), 64'(EXP_SECOND));
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset while beats are held.
    stall_fill(acc);
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_out_data", 64'(out_data), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    pushed = pushed - exp_q.size();
    exp_q.delete();
    @(posedge CLK); @(posedge CLK); #2;
    nRST = 1'b1;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    send(32'hCAFEF00D, 4'b0111, SWAP_HALF);
    check_eq("post_rst_valid", 64'(out_valid), 64'd1);
    check_eq("post_rst_data", 64'(out_data), 64'hFECA0DF0);
    check_eq("post_rst_be", 64'(out_be), 64'hB);
    @(posedge CLK); #1;
    check_eq("post_rst_alone", 64'(out_valid), 64'd0);

    // Random valid/ready traffic, 10k accepted beats.
    sent = 0;
    in_valid  = 1'b0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      @(negedge CLK);
      fired = in_valid && in_ready;
      @(posedge CLK);
      #1;
      if (fired) sent++;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0) && (sent < 10000);
        in_data  = $urandom;
        in_be    = 4'($urandom_range(0, 15));
        in_mode  = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check_eq("random_sent", 64'(sent), 64'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge CLK);
    #1;
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("push_pop", 64'(popped), 64'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
